// File: rtl/knockback_pkg.sv
// Shared types and constants for the knockback motion generator.
// Optional re-hit (combo) support is enabled by defining KB_COMBO_EN.
package knockback_pkg;

   localparam int unsigned SPEED_W     = 4;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned COMBO_W     = 3;
   localparam int unsigned PROFILE_LEN = 6;

   // Per-frame punch speeds; entry 0 is played first
   localparam logic [PROFILE_LEN-1:0][SPEED_W-1:0] PROFILE =
      {4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};

   localparam logic [SPEED_W-1:0] BLOCK_SPEED = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUSH,
      ST_BLOCK,
      ST_CLAMP
   } kb_state_e;

   // Speed magnitude to signed x delta; dir=1 moves toward the right wall
   function automatic logic signed [15:0] speed_to_motion(input logic [15:0] speed,
                                                          input logic        dir);
      return dir ? signed'(speed) : -signed'(speed);
   endfunction

endpackage

// File: rtl/knockback_wall_dist.sv
// Distance from the sprite edge to the wall it is being pushed toward,
// floored at zero when the sprite already overlaps the wall.
module knockback_wall_dist
   import knockback_pkg::*;
#(
   parameter bit          DIR       = 1'b1,
   parameter int unsigned POS_W     = 10,
   parameter int unsigned SPRITE_W  = 125,
   parameter int unsigned BOUND_MIN = 10,
   parameter int unsigned BOUND_MAX = 629
) (
   input  logic [POS_W-1:0] xpos_i,
   output logic [POS_W-1:0] dist_o
);

   localparam int unsigned DW = POS_W + 2;

   logic signed [DW-1:0] x_s;
   logic signed [DW-1:0] raw_s;

   always_comb begin
      x_s = signed'(DW'(xpos_i));
      if (DIR) begin
         raw_s = signed'(DW'(BOUND_MAX)) - (x_s + signed'(DW'(SPRITE_W)));
      end else begin
         raw_s = x_s - signed'(DW'(BOUND_MIN));
      end
      dist_o = raw_s[DW-1] ? '0 : POS_W'(raw_s);
   end

endmodule

// File: rtl/knockback_ctrl.sv
// Frame-rate knockback generator: plays a punch profile or a block push and
// stops exactly at the wall. Define KB_COMBO_EN to let re-hits restart a punch.
module knockback_ctrl
   import knockback_pkg::*;
#(
   parameter bit          DIR          = 1'b1,
   parameter int unsigned POS_W        = 10,
   parameter int unsigned MOT_W        = 8,
   parameter int unsigned SPRITE_W     = 125,
   parameter int unsigned BOUND_MIN    = 10,
   parameter int unsigned BOUND_MAX    = 629,
   parameter int unsigned BLOCK_FRAMES = 1
) (
   input  logic                    clk,
   input  logic                    Reset,
   input  logic                    frame_tick,
   input  logic                    punch,
   input  logic                    block,
   input  logic [POS_W-1:0]        xpos,
   output logic signed [MOT_W-1:0] motion,
   output logic                    busy,
   output logic                    wall_hit,
   output logic [COMBO_W-1:0]      combo_cnt
);

   kb_state_e                state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     punch_q, punch_d;
   logic                     block_q, block_d;
   logic signed [MOT_W-1:0]  motion_q, motion_d;
   logic                     busy_q, busy_d;
   logic                     wall_q, wall_d;
`ifdef KB_COMBO_EN
   logic [COMBO_W-1:0]       combo_q, combo_d;
`endif

   logic [POS_W-1:0]         dist_c;
   logic                     punch_req_c;
   logic                     block_req_c;
   logic                     launch_c;
   logic [SPEED_W-1:0]       spd_c;
   logic [IDX_W-1:0]         idx_nx_c;

   knockback_wall_dist #(
      .DIR       (DIR),
      .POS_W     (POS_W),
      .SPRITE_W  (SPRITE_W),
      .BOUND_MIN (BOUND_MIN),
      .BOUND_MAX (BOUND_MAX)
   ) u_wall_dist (
      .xpos_i (xpos),
      .dist_o (dist_c)
   );

   // Requests seen in the tick cycle itself count toward that tick
   assign punch_req_c = punch_q | punch;
   assign block_req_c = block_q | block;
   assign idx_nx_c    = IDX_W'(idx_q + IDX_W'(1));

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         punch_q  <= 1'b0;
         block_q  <= 1'b0;
         motion_q <= '0;
         busy_q   <= 1'b0;
         wall_q   <= 1'b0;
`ifdef KB_COMBO_EN
         combo_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         punch_q  <= punch_d;
         block_q  <= block_d;
         motion_q <= motion_d;
         busy_q   <= busy_d;
         wall_q   <= wall_d;
`ifdef KB_COMBO_EN
         combo_q  <= combo_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      motion_d = motion_q;
      busy_d   = busy_q;
      wall_d   = wall_q;
`ifdef KB_COMBO_EN
      combo_d  = combo_q;
`endif
      launch_c = 1'b0;
      spd_c    = '0;
      punch_d  = frame_tick ? 1'b0 : punch_req_c;
      block_d  = frame_tick ? 1'b0 : block_req_c;

      if (frame_tick) begin
         motion_d = '0;
         wall_d   = 1'b0;

         // Each launch emits its first speed on the tick that starts it
         unique case (state_q)
            ST_IDLE: begin
               if (block_req_c) begin
                  state_d  = ST_BLOCK;
                  cnt_d    = '0;
                  launch_c = 1'b1;
                  spd_c    = BLOCK_SPEED;
               end else if (punch_req_c) begin
                  state_d  = ST_PUSH;
                  idx_d    = '0;
                  launch_c = 1'b1;
                  spd_c    = PROFILE[0];
               end
            end
            ST_PUSH: begin
`ifdef KB_COMBO_EN
               if (punch_req_c) begin
                  idx_d    = '0;
                  launch_c = 1'b1;
                  spd_c    = PROFILE[0];
                  combo_d  = (combo_q == COMBO_W'(7)) ? combo_q
                                                       : COMBO_W'(combo_q + COMBO_W'(1));
               end else
`endif
               if (idx_q == IDX_W'(PROFILE_LEN - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d    = idx_nx_c;
                  launch_c = 1'b1;
                  spd_c    = PROFILE[idx_nx_c];
               end
            end
            ST_BLOCK: begin
               if (cnt_q == CNT_W'(BLOCK_FRAMES - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d    = CNT_W'(cnt_q + CNT_W'(1));
                  launch_c = 1'b1;
                  spd_c    = BLOCK_SPEED;
               end
            end
            ST_CLAMP: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         // Final step shortened so the sprite lands exactly on the wall
         if (launch_c) begin
            if (dist_c < POS_W'(spd_c)) begin
               motion_d = MOT_W'(speed_to_motion(16'(dist_c), DIR));
               wall_d   = 1'b1;
               state_d  = ST_CLAMP;
            end else begin
               motion_d = MOT_W'(speed_to_motion(16'(spd_c), DIR));
            end
         end

         busy_d = (state_d != ST_IDLE);
`ifdef KB_COMBO_EN
         if (state_d == ST_IDLE) begin
            combo_d = '0;
         end
`endif
      end
   end

   assign motion   = motion_q;
   assign busy     = busy_q;
   assign wall_hit = wall_q;
`ifdef KB_COMBO_EN
   assign combo_cnt = combo_q;
`else
   assign combo_cnt = '0;
`endif

endmodule

// File: tb/tb_knockback_ctrl.sv
// Scoreboard bench for knockback_ctrl: one right-pushing and one left-pushing
// instance share stimulus and are checked against a plan-list reference model.
module tb_knockback_ctrl;

   localparam int BMIN  = 10;
   localparam int BMAX  = 629;
   localparam int SPR   = 125;
`ifdef KB_COMBO_EN
   localparam bit COMBO = 1'b1;
`else
   localparam bit COMBO = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              frame_tick;
   logic              punch;
   logic              block;
   logic [9:0]        xpos;
   logic signed [7:0] mot_r, mot_l;
   logic              busy_r, busy_l;
   logic              wall_r, wall_l;
   logic [2:0]        combo_r, combo_l;

   knockback_ctrl #(.DIR(1'b1), .BLOCK_FRAMES(3)) u_dut_r (
      .clk (clk), .Reset (rst_n), .frame_tick (frame_tick), .punch (punch),
      .block (block), .xpos (xpos), .motion (mot_r), .busy (busy_r),
      .wall_hit (wall_r), .combo_cnt (combo_r)
   );

   knockback_ctrl #(.DIR(1'b0), .BLOCK_FRAMES(1)) u_dut_l (
      .clk (clk), .Reset (rst_n), .frame_tick (frame_tick), .punch (punch),
      .block (block), .xpos (xpos), .motion (mot_l), .busy (busy_l),
      .wall_hit (wall_l), .combo_cnt (combo_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int m0; int b0; int w0; int c0;
      int m1; int b1; int w1; int c1;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: each lane holds a list of speeds still to play
   int lane_dir[2] = '{1, 0};
   int lane_bf[2]  = '{3, 1};
   int prof[6]     = '{8, 8, 7, 6, 5, 5};
   int act[2], kind[2], pos[2], len[2], combo[2];
   int plan[2][16];
   bit pf, bf;

   task automatic model_reset();
      for (int ln = 0; ln < 2; ln++) begin
         act[ln] = 0; kind[ln] = 0; pos[ln] = 0; len[ln] = 0; combo[ln] = 0;
      end
      pf = 1'b0;
      bf = 1'b0;
   endtask

   task automatic load_profile(input int ln);
      for (int k = 0; k < 6; k++) plan[ln][k] = prof[k];
      pos[ln] = 0;
      len[ln] = 6;
   endtask

   task automatic model_tick(input int ln, input bit pr, input bit br, input int x,
                             output int mot, output int bz, output int wh, output int cb);
      int d;
      int s;
      d   = lane_dir[ln] ? BMAX - (x + SPR) : x - BMIN;
      if (d < 0) d = 0;
      mot = 0;
      wh  = 0;
      if (act[ln] == 0) begin
         if (br) begin
            for (int k = 0; k < lane_bf[ln]; k++) plan[ln][k] = 4;
            pos[ln] = 0; len[ln] = lane_bf[ln]; act[ln] = 1; kind[ln] = 2;
         end else if (pr) begin
            load_profile(ln); act[ln] = 1; kind[ln] = 1;
         end
      end else if (COMBO && kind[ln] == 1 && pr) begin
         load_profile(ln);
         combo[ln] = (combo[ln] < 7) ? combo[ln] + 1 : 7;
      end
      if (act[ln] != 0) begin
         if (pos[ln] < len[ln]) begin
            s = plan[ln][pos[ln]];
            pos[ln]++;
            if (d < s) begin
               mot = d; wh = 1; len[ln] = pos[ln]; kind[ln] = 3;
            end else begin
               mot = s;
            end
         end else begin
            act[ln] = 0; combo[ln] = 0;
         end
      end
      if (lane_dir[ln] == 0) mot = -mot;
      bz = act[ln];
      cb = combo[ln];
   endtask

   // One clock of stimulus; an expectation is queued for every tick or reset edge
   task automatic cyc(input bit rst, input bit tk, input bit p, input bit b, input int x);
      exp_t e;
      bit   pr, br;
      @(negedge clk);
      rst_n      = rst;
      frame_tick = tk;
      punch      = p;
      block      = b;
      xpos       = 10'(x);
      if (!rst) begin
         model_reset();
         e = '{default: 0};
         exp_q.push_back(e);
      end else if (tk) begin
         pr = pf | p;
         br = bf | b;
         pf = 1'b0;
         bf = 1'b0;
         model_tick(0, pr, br, x, e.m0, e.b0, e.w0, e.c0);
         model_tick(1, pr, br, x, e.m1, e.b1, e.w1, e.c1);
         exp_q.push_back(e);
      end else begin
         pf = pf | p;
         bf = bf | b;
      end
   endtask

   task automatic run_frames(input int n, input int x);
      for (int f = 0; f < n; f++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, x);
         cyc(1'b1, 1'b0, 1'b0, 1'b0, x);
         cyc(1'b1, 1'b0, 1'b0, 1'b0, x);
      end
   endtask

   task automatic chk(input string name, input int act_v, input int exp_v);
      n_checks++;
      if (act_v != exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act_v, exp_v);
      end
   endtask

   task automatic cmp_all(input exp_t e, input string tag);
      chk({tag, "_motion_r"}, int'(mot_r), e.m0);
      chk({tag, "_busy_r"},   int'(busy_r), e.b0);
      chk({tag, "_wall_r"},   int'(wall_r), e.w0);
      chk({tag, "_combo_r"},  int'(combo_r), e.c0);
      chk({tag, "_motion_l"}, int'(mot_l), e.m1);
      chk({tag, "_busy_l"},   int'(busy_l), e.b1);
      chk({tag, "_wall_l"},   int'(wall_l), e.w1);
      chk({tag, "_combo_l"},  int'(combo_l), e.c1);
   endtask

   // Monitor: pops on every tick/reset edge, otherwise checks outputs hold
   initial begin
      exp_t e;
      exp_t last;
      bit   have;
      have = 1'b0;
      @(negedge clk);
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || frame_tick) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 0, 1);
            end else begin
               e    = exp_q.pop_front();
               last = e;
               have = 1'b1;
               cmp_all(e, rst_n ? "tick" : "reset");
            end
         end else if (have) begin
            cmp_all(last, "hold");
         end
      end
   end

   initial begin
      int x;
      int flen;
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      punch      = 1'b0;
      block      = 1'b0;
      xpos       = '0;
      model_reset();

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Full profile, punch arriving between ticks
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 400);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 400);
      run_frames(9, 400);

      // Right lane reaches the wall after one short step
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 500);
      run_frames(8, 500);

      // Block and punch together in the tick cycle
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 200);
      run_frames(6, 200);

      // Reset in the third push frame
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 300);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 300);
      run_frames(2, 300);

      // Re-hit during the fourth frame
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 300);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 300);
      run_frames(10, 300);

      // Left lane already past the wall
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 5);
      run_frames(5, 5);

      // Randomised frames, biased toward both walls
      for (int f = 0; f < 250; f++) begin
         flen = int'($urandom_range(2, 6));
         case ($urandom_range(0, 3))
            0:       x = int'($urandom_range(0, 1023));
            1:       x = int'($urandom_range(480, 520));
            2:       x = int'($urandom_range(0, 30));
            default: x = int'($urandom_range(200, 400));
         endcase
         for (int c = 0; c < flen; c++) begin
            cyc($urandom_range(0, 199) != 0, c == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 23) == 0, x);
         end
      end

      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
